// File: rtl/mem_arbiter.sv
// mem_arbiter: lets NUM_CH cache controllers share one block-wide memory port, one access at a time.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module mem_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 6,
  parameter int BLOCK_W = 128
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [NUM_CH-1:0]           REQ_READ,
  input  logic [NUM_CH-1:0]           REQ_WRITE,
  input  logic [NUM_CH*ADDR_W-1:0]    REQ_ADDRESS,
  input  logic [NUM_CH*BLOCK_W-1:0]   REQ_WRITEDATA,
  output logic [BLOCK_W-1:0]          REQ_READDATA,
  output logic [NUM_CH-1:0]           REQ_BUSYWAIT,
  output logic                        MEM_READ,
  output logic                        MEM_WRITE,
  output logic [ADDR_W-1:0]           MEM_ADDRESS,
  output logic [BLOCK_W-1:0]          MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]          MEM_READDATA,
  input  logic                        MEM_BUSYWAIT
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    grant_q, grant_d;
  logic [CH_W-1:0]    last_grant_q, last_grant_d;
  logic [CH_W-1:0]    winner;
  logic               seen_busy_q, seen_busy_d;
  logic [BLOCK_W-1:0] rdata_q, rdata_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [NUM_CH-1:0]  req;
  logic               any_req;

  assign req     = REQ_READ | REQ_WRITE;
  assign any_req = |req;

  // Scan from the far end so the candidate closest to the search start is the last one assigned.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) winner = CH_W'(i);
    end
`else
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req[idx]) winner = CH_W'(idx);
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   if (seen_busy_q && !MEM_BUSYWAIT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side strobes are registered at the grant edge and held until the access completes.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    seen_busy_d  = seen_busy_q;
    rdata_d      = rdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      IDLE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (any_req) begin
          grant_d     = winner;
          seen_busy_d = 1'b0;
          mem_write_d = REQ_WRITE[winner];
          mem_read_d  = REQ_READ[winner] & ~REQ_WRITE[winner];
          mem_addr_d  = REQ_ADDRESS[int'(winner)*ADDR_W +: ADDR_W];
          mem_wdata_d = REQ_WRITEDATA[int'(winner)*BLOCK_W +: BLOCK_W];
        end
      end
      ISSUE: begin
        if (MEM_BUSYWAIT) seen_busy_d = 1'b1;
        if (seen_busy_q && !MEM_BUSYWAIT) begin
          if (mem_read_q) rdata_d = MEM_READDATA;
          last_grant_d = grant_q;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
        end
      end
      DONE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
      default: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      grant_q      <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      seen_busy_q  <= 1'b0;
      rdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      seen_busy_q  <= seen_busy_d;
      rdata_q      <= rdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // A requester stalls until the single DONE cycle of its own grant.
  always_comb begin
    REQ_BUSYWAIT = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      REQ_BUSYWAIT[i] = req[i] & ~((state_q == DONE) && (grant_q == CH_W'(i)));
    end
  end

  assign REQ_READDATA  = rdata_q;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter with four channels and a behavioural memory.
// Honours ARB_FIXED_PRIO_EN in its reference arbitration rule.
module tb_mem_arbiter;

  localparam int NUM_CH  = 4;
  localparam int ADDR_W  = 6;
  localparam int BLOCK_W = 128;
  localparam int DEPTH   = 2 ** ADDR_W;

  typedef struct {
    int                 ch;
    logic               is_wr;
    logic [ADDR_W-1:0]  addr;
    logic [BLOCK_W-1:0] wdata;
  } txn_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_CH-1:0]         req_read;
  logic [NUM_CH-1:0]         req_write;
  logic [NUM_CH*ADDR_W-1:0]  req_address;
  logic [NUM_CH*BLOCK_W-1:0] req_writedata;
  logic [BLOCK_W-1:0]        req_readdata;
  logic [NUM_CH-1:0]         req_busywait;
  logic                      mem_read;
  logic                      mem_write;
  logic [ADDR_W-1:0]         mem_address;
  logic [BLOCK_W-1:0]        mem_writedata;
  logic [BLOCK_W-1:0]        mem_readdata;
  logic                      mem_busywait;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [NUM_CH-1:0] active;
  int                done_cnt [NUM_CH];
  int                ack_cnt  [NUM_CH];
  int                done_log [$];
  int                forced_lat;
  int                mem_fin_cnt;
  txn_t              exp_q [$];

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) u_dut (
    .CLK(clk),
    .RESET(reset),
    .REQ_READ(req_read),
    .REQ_WRITE(req_write),
    .REQ_ADDRESS(req_address),
    .REQ_WRITEDATA(req_writedata),
    .REQ_READDATA(req_readdata),
    .REQ_BUSYWAIT(req_busywait),
    .MEM_READ(mem_read),
    .MEM_WRITE(mem_write),
    .MEM_ADDRESS(mem_address),
    .MEM_WRITEDATA(mem_writedata),
    .MEM_READDATA(mem_readdata),
    .MEM_BUSYWAIT(mem_busywait)
  );

  task automatic checkOutput(input string name, input logic [BLOCK_W-1:0] actual,
                             input logic [BLOCK_W-1:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [BLOCK_W-1:0] init_block(input int a);
    if (a == 5) return 128'hDEADBEEF_00000000_00000000_00000001;
    return {32'hC0DE0000 + 32'(a), ~(32'(a)), 32'h12345678 ^ 32'(a), 32'(a)};
  endfunction

  // Reference arbitration rule: who should win given the pending set and the last served channel.
  function automatic int pickWinner(input logic [NUM_CH-1:0] pend, input int last);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_CH; i++) if (pend[i]) return i;
`else
    for (int k = 1; k <= NUM_CH; k++) if (pend[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
`endif
    return -1;
  endfunction

  // Behavioural memory: busy for a set number of cycles per access, aborts when strobes drop.
  initial begin
    logic [BLOCK_W-1:0] mem_array [DEPTH];
    int                 mem_cnt;
    logic               mem_active;
    for (int a = 0; a < DEPTH; a++) mem_array[a] = init_block(a);
    mem_busywait = 1'b0;
    mem_readdata = '0;
    mem_active   = 1'b0;
    mem_cnt      = 0;
    mem_fin_cnt  = 0;
    forever begin
      @(negedge clk);
      if (!(mem_read || mem_write)) begin
        mem_active   = 1'b0;
        mem_busywait = 1'b0;
      end else if (!mem_active) begin
        mem_active   = 1'b1;
        mem_busywait = 1'b1;
        mem_cnt      = (forced_lat > 0) ? forced_lat - 1 : int'($urandom_range(3, 0));
      end else if (mem_busywait) begin
        if (mem_cnt > 0) mem_cnt--;
        else begin
          mem_busywait = 1'b0;
          if (mem_write) mem_array[mem_address] = mem_writedata;
          else           mem_readdata = mem_array[mem_address];
          mem_fin_cnt++;
        end
      end
    end
  end

  // Monitor: predicts each grant from the pending set, then scores the DONE cycle against it.
  initial begin
    logic [BLOCK_W-1:0] shadow [DEPTH];
    logic [BLOCK_W-1:0] model_rdata;
    logic [NUM_CH-1:0]  pend, done_vec;
    logic               strobe, strobe_prev, fin;
    int                 model_last, fin_seen, w, d;
    txn_t               t;
    for (int a = 0; a < DEPTH; a++) shadow[a] = init_block(a);
    model_rdata = '0;
    strobe_prev = 1'b0;
    model_last  = NUM_CH - 1;
    fin_seen    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        exp_q.delete();
        model_last  = NUM_CH - 1;
        model_rdata = '0;
        strobe_prev = 1'b0;
        fin_seen    = mem_fin_cnt;
        checkOutput("rst_mem_read", BLOCK_W'(mem_read), '0);
        checkOutput("rst_mem_write", BLOCK_W'(mem_write), '0);
        checkOutput("rst_mem_address", BLOCK_W'(mem_address), '0);
        checkOutput("rst_mem_writedata", mem_writedata, '0);
        checkOutput("rst_readdata", req_readdata, '0);
      end else begin
        pend   = req_read | req_write;
        strobe = mem_read | mem_write;
        checkOutput("idle_busywait", BLOCK_W'(req_busywait & ~pend), '0);
        if (strobe && !strobe_prev) begin
          w = pickWinner(pend, model_last);
          if (w < 0) begin
            checkOutput("spurious_grant", BLOCK_W'(strobe), '0);
          end else begin
            t.ch    = w;
            t.is_wr = req_write[w];
            t.addr  = req_address[w*ADDR_W +: ADDR_W];
            t.wdata = req_writedata[w*BLOCK_W +: BLOCK_W];
            exp_q.push_back(t);
            checkOutput("grant_mem_write", BLOCK_W'(mem_write), BLOCK_W'(t.is_wr));
            checkOutput("grant_mem_read", BLOCK_W'(mem_read), BLOCK_W'(!t.is_wr));
            checkOutput("grant_mem_address", BLOCK_W'(mem_address), BLOCK_W'(t.addr));
            checkOutput("grant_mem_writedata", mem_writedata, t.wdata);
          end
        end else if (strobe && exp_q.size() != 0) begin
          checkOutput("hold_mem_address", BLOCK_W'(mem_address), BLOCK_W'(exp_q[0].addr));
          checkOutput("hold_mem_writedata", mem_writedata, exp_q[0].wdata);
        end
        strobe_prev = strobe;

        done_vec = pend & ~req_busywait;
        fin      = (mem_fin_cnt != fin_seen);
        fin_seen = mem_fin_cnt;
        if (done_vec != 0 || fin)
          checkOutput("done_latency", BLOCK_W'(done_vec != 0), BLOCK_W'(fin));
        if (done_vec != 0) begin
          checkOutput("done_onehot", BLOCK_W'($onehot(done_vec)), BLOCK_W'(1));
          checkOutput("done_strobes", BLOCK_W'(strobe), '0);
          d = 0;
          for (int i = NUM_CH - 1; i >= 0; i--) if (done_vec[i]) d = i;
          if (exp_q.size() == 0) begin
            checkOutput("done_unexpected", BLOCK_W'(done_vec), '0);
          end else begin
            t = exp_q.pop_front();
            checkOutput("done_channel", BLOCK_W'(d), BLOCK_W'(t.ch));
            if (t.is_wr) begin
              checkOutput("wr_readdata_kept", req_readdata, model_rdata);
              shadow[t.addr] = t.wdata;
            end else begin
              model_rdata = shadow[t.addr];
              checkOutput("rd_data", req_readdata, model_rdata);
            end
            model_last = t.ch;
          end
          done_log.push_back(d);
          done_cnt[d]++;
        end
      end
    end
  end

  // Advance to the next falling edge and release any channel whose DONE was just seen.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) begin
      if (done_cnt[i] != ack_cnt[i]) begin
        ack_cnt[i]   = done_cnt[i];
        req_read[i]  = 1'b0;
        req_write[i] = 1'b0;
        active[i]    = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input int ch, input logic rd, input logic wr,
                               input logic [ADDR_W-1:0] addr, input logic [BLOCK_W-1:0] data);
    int n = 0;
    while (active[ch] && n < 200) begin
      tick();
      n++;
    end
    checkOutput("issue_wait", BLOCK_W'(active[ch]), '0);
    req_address[ch*ADDR_W +: ADDR_W]     = addr;
    req_writedata[ch*BLOCK_W +: BLOCK_W] = data;
    req_read[ch]  = rd;
    req_write[ch] = wr;
    active[ch]    = 1'b1;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (active != 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_timeout", BLOCK_W'(active), '0);
  endtask

  function automatic logic [BLOCK_W-1:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int                 base, n, ch, op;
    logic [BLOCK_W-1:0] held;
    reset         = 1'b1;
    req_read      = '0;
    req_write     = '0;
    req_address   = '0;
    req_writedata = '0;
    active        = '0;
    forced_lat    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      done_cnt[i] = 0;
      ack_cnt[i]  = 0;
    end
    repeat (2) tick();
    reset = 1'b0;

    $display("[TB] single read on ch1");
    forced_lat = 5;
    applyStimulus(1, 1'b1, 1'b0, 6'h05, '0);
    waitIdle(60);
    checkOutput("single_rd_block", req_readdata, 128'hDEADBEEF_00000000_00000000_00000001);

    $display("[TB] simultaneous ch0 read / ch1 write after reset");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    forced_lat = 2;
    base = done_log.size();
    applyStimulus(0, 1'b1, 1'b0, 6'h01, '0);
    applyStimulus(1, 1'b0, 1'b1, 6'h02, rand_block());
    waitIdle(60);
    checkOutput("simul_first", BLOCK_W'(done_log[base]), BLOCK_W'(0));
    checkOutput("simul_second", BLOCK_W'(done_log[base+1]), BLOCK_W'(1));

    $display("[TB] fairness with ch0 and ch1 always requesting");
    forced_lat = 0;
    base = done_log.size();
    n = 0;
    applyStimulus(0, 1'b1, 1'b0, 6'($urandom_range(63, 0)), '0);
    applyStimulus(1, 1'b0, 1'b1, 6'($urandom_range(63, 0)), rand_block());
    while (done_log.size() - base < 6 && n < 400) begin
      tick();
      n++;
      if (!active[0]) applyStimulus(0, 1'b1, 1'b0, 6'($urandom_range(63, 0)), '0);
      if (!active[1]) applyStimulus(1, 1'b0, 1'b1, 6'($urandom_range(63, 0)), rand_block());
    end
    waitIdle(200);
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      checkOutput("fair_order", BLOCK_W'(done_log[base+k]), BLOCK_W'(0));
`else
      checkOutput("fair_order", BLOCK_W'(done_log[base+k]), BLOCK_W'(k % 2));
`endif
    end

    $display("[TB] reset two cycles into a ch0 read");
    forced_lat = 10;
    applyStimulus(0, 1'b1, 1'b0, 6'h07, '0);
    n = 0;
    while (!mem_read && n < 50) begin
      tick();
      n++;
    end
    checkOutput("abort_wait_read", BLOCK_W'(mem_read), BLOCK_W'(1));
    tick();
    tick();
    reset = 1'b1;
    forced_lat = 3;
    tick();
    reset = 1'b0;
    checkOutput("abort_mem_read", BLOCK_W'(mem_read), '0);
    checkOutput("abort_readdata", req_readdata, '0);
    checkOutput("abort_busywait", BLOCK_W'(req_busywait[0]), BLOCK_W'(1));
    waitIdle(60);
    checkOutput("abort_retry_data", req_readdata, init_block(7));

    $display("[TB] read+write conflict on ch0 at 0x3F");
    held = req_readdata;
    applyStimulus(0, 1'b1, 1'b1, 6'h3F, rand_block());
    waitIdle(60);
    checkOutput("conflict_readdata", req_readdata, held);

    $display("[TB] ch3 and ch1 request after ch2 was served");
    applyStimulus(2, 1'b1, 1'b0, 6'h10, '0);
    waitIdle(60);
    base = done_log.size();
    applyStimulus(3, 1'b1, 1'b0, 6'h11, '0);
    applyStimulus(1, 1'b1, 1'b0, 6'h12, '0);
    waitIdle(60);
`ifdef ARB_FIXED_PRIO_EN
    checkOutput("rr4_first", BLOCK_W'(done_log[base]), BLOCK_W'(1));
    checkOutput("rr4_second", BLOCK_W'(done_log[base+1]), BLOCK_W'(3));
`else
    checkOutput("rr4_first", BLOCK_W'(done_log[base]), BLOCK_W'(3));
    checkOutput("rr4_second", BLOCK_W'(done_log[base+1]), BLOCK_W'(1));
`endif

    $display("[TB] random traffic");
    forced_lat = 0;
    repeat (300) begin
      tick();
      ch = int'($urandom_range(NUM_CH - 1, 0));
      if (!active[ch] && $urandom_range(1, 0) == 1) begin
        op = int'($urandom_range(2, 0));
        applyStimulus(ch, 1'(op != 1), 1'(op != 0), 6'($urandom_range(63, 0)), rand_block());
      end
    end
    waitIdle(400);
    tick();
    checkOutput("scoreboard_empty", BLOCK_W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-channel arbiter that lets several cache controllers share one block-wide backing memory port.
- Typical use: icache (ch0) and dcache (ch1) share one unified memory, replacing the split instruction/data memory arrangement.
- Uses the same read/write/busywait handshake as the caches and memories on both sides.
- Successor to the testbench-level OR of busywaits: it adds real arbitration, per-channel stall and a shared read-data return.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8).
- ADDR_W, 6, block address width.
- BLOCK_W, 128, data block width in bits.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ_READ  input  NUM_CH  per-channel read request, held until that channel's busywait is low.
- REQ_WRITE  input  NUM_CH  per-channel write request, same hold rule.
- REQ_ADDRESS  input  NUM_CH*ADDR_W  packed addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
- REQ_WRITEDATA  input  NUM_CH*BLOCK_W  packed write blocks.
- REQ_READDATA  output  BLOCK_W  shared registered read block; valid for the granted channel in DONE.
- REQ_BUSYWAIT  output  NUM_CH  per-channel stall.
- MEM_READ  output  1  memory read strobe.
- MEM_WRITE  output  1  memory write strobe.
- MEM_ADDRESS  output  ADDR_W  memory block address.
- MEM_WRITEDATA  output  BLOCK_W  memory write block.
- MEM_READDATA  input  BLOCK_W  memory read block.
- MEM_BUSYWAIT  input  1  memory busy.

Behaviour:
- Reset (synchronous, active-high, on a CLK edge): state=IDLE, grant=0, last_grant=NUM_CH-1, seen_busy=0, REQ_READDATA=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
- Channel request: req[i] = REQ_READ[i] | REQ_WRITE[i]. If both are high on a channel, the write wins.
- REQ_BUSYWAIT[i] (combinational) = req[i] & ~(state==DONE & grant==i). Any requesting channel stalls until its own DONE cycle.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - MEM strobes are 0.
  - If any req is set, pick the winner by round-robin: first requesting index searching from last_grant+1 upward, wrapping modulo NUM_CH.
  - Register grant, clear seen_busy, go ISSUE.
  - If no req is set, stay in IDLE.
- ISSUE:
  - MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA are driven from the granted channel (registered at the grant edge and held stable).
  - Each edge: if MEM_BUSYWAIT=1, set seen_busy.
  - If seen_busy=1 and MEM_BUSYWAIT=0: latch MEM_READDATA into REQ_READDATA (reads only; writes leave it unchanged), set last_grant=grant, go DONE.
- DONE:
  - Lasts exactly one cycle.
  - MEM strobes are 0 and the granted channel's busywait is low, so the requester consumes data and drops its request.
  - Next state is IDLE unconditionally; no back-to-back grant from DONE.
- Latency: from request seen in IDLE to DONE = 1 (grant) + memory busy cycles + 1.
- Starvation-free: each waiting channel is served within NUM_CH grants.
- Request withdrawn during ISSUE: ignored. The transaction completes and DONE still occurs.
- Simultaneous requests at IDLE: exactly one grant; the others keep busywait high.
- RESET during ISSUE: strobes drop at that edge and state returns to IDLE. The memory must tolerate an aborted access, matching existing memory models.
- MEM_BUSYWAIT never rising during ISSUE: the arbiter waits indefinitely (no timeout).

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- When defined: fixed priority, lowest asserted index always wins; last_grant is still updated but unused.
- When undefined (default): round-robin as above.

Test Plan:
- Single read: ch1 read at address 0x05, memory busy for 5 cycles returning 0xDEADBEEF_...01.
  Required: MEM_ADDRESS=0x05, REQ_BUSYWAIT[1] low only in DONE, REQ_READDATA equals the returned block, REQ_BUSYWAIT[0] stays 0 throughout.
- Simultaneous: ch0 read 0x01 and ch1 write 0x02 asserted in the same cycle after reset.
  Required: ch0 served first (last_grant reset to 1), then ch1. MEM_WRITEDATA equals ch1 data only during ch1's ISSUE.
- Fairness: both channels request continuously for 6 transactions.
  Required: grants alternate 0,1,0,1,0,1. With ARB_FIXED_PRIO_EN: ch1 is never served while ch0 is held.
- Reset mid-ISSUE: RESET asserted 2 cycles into a ch0 read.
  Required: MEM_READ=0 and state IDLE after that edge, REQ_READDATA=0. A fresh request afterwards completes normally.
- Read+write conflict: ch0 asserts both REQ_READ and REQ_WRITE at address 0x3F.
  Required: MEM_WRITE=1, MEM_READ=0, REQ_READDATA unchanged.
- NUM_CH=4: channels 3 and 1 request while last_grant=2.
  Required: ch3 is granted before ch1.
